spi_cmd_sequencer: RTL and testbench

Command-queue stage placed directly upstream of the team's SPI register master. Buffers host register-access words in a FIFO and issues them one at a time over the master's in_data/in_ena/busy handshake. Captures the master's parallel readback (miso_reg/miso_reg_ena) for read-type commands and returns it to the host with a valid strobe. All logic is on posedge sys_clk.

---
 rtl/spi_cmd_sequencer.sv | 165 ++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// Command FIFO feeding the SPI register master one frame at a time, with readback capture.
// Define SPI_SEQ_TIMEOUT_EN to abandon a command when the master never raises busy.
module spi_cmd_sequencer #(
    parameter int         WIDTH       = 24,
    parameter int         DEPTH       = 16,
    parameter int         RD_FLAG_BIT = 23,
    parameter logic [7:0] TIMEOUT     = 8'd255
) (
    input  logic                     sys_clk,
    input  logic                     n_rst,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_wr_ena,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_idle,
    output logic [WIDTH-1:0]         o_spi_in_data,
    output logic                     o_spi_in_ena,
    input  logic                     i_spi_busy,
    input  logic [WIDTH-1:0]         i_spi_miso_reg,
    input  logic                     i_spi_miso_reg_ena,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_timeout_err
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        RD_FLAG_BIT >= WIDTH || TIMEOUT == 8'd0) begin : g_param_check
        $error("spi_cmd_sequencer: invalid DEPTH, RD_FLAG_BIT or TIMEOUT");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [AW:0]       r_level;
    logic              r_overflow;
    logic [WIDTH-1:0]  r_in_data;
    logic              r_in_ena, w_in_ena_nxt;
    logic              r_is_read, r_captured;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              w_push, w_pop, w_capture, w_tmo_hit;

    assign o_full   = (r_level == (AW+1)'(DEPTH));
    assign w_push   = i_wr_ena & ~o_full;
    assign w_capture = r_is_read & ~r_captured & i_spi_miso_reg_ena &
                       ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE));

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (i_wr_ena && o_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // in_ena is registered, so it is requested one state ahead of where it is seen
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_in_ena_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0 && !i_spi_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_in_ena_nxt = 1'b1;
                w_state_nxt  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_spi_busy)     w_state_nxt  = S_WAIT_DONE;
                else if (w_tmo_hit) w_state_nxt  = S_IDLE;
                else                w_in_ena_nxt = 1'b1;
            end
            S_WAIT_DONE: begin
                if (!i_spi_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_in_data  <= '0;
            r_in_ena   <= 1'b0;
            r_is_read  <= 1'b0;
            r_captured <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_in_ena   <= w_in_ena_nxt;
            r_rd_valid <= w_capture;
            if (w_pop) begin
                r_in_data  <= r_mem[r_rptr];
                r_is_read  <= r_mem[r_rptr][RD_FLAG_BIT];
                r_captured <= 1'b0;
            end
            if (w_capture) begin
                r_rd_data  <= i_spi_miso_reg;
                r_captured <= 1'b1;
            end
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_timeout_err;

    assign w_tmo_hit = (r_tmo_cnt == TIMEOUT - 8'd1);

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_WAIT_BUSY) r_tmo_cnt <= r_tmo_cnt + 8'd1;
            else                        r_tmo_cnt <= '0;
            if (r_state == S_WAIT_BUSY && !i_spi_busy && w_tmo_hit) r_timeout_err <= 1'b1;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign w_tmo_hit     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    assign o_level       = r_level;
    assign o_overflow    = r_overflow;
    assign o_idle        = (r_level == '0) && (r_state == S_IDLE);
    assign o_spi_in_data = r_in_data;
    assign o_spi_in_ena  = r_in_ena;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer with a behavioural SPI master and an order/readback model.
module tb_spi_cmd_sequencer;
    logic        sys_clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [23:0] wr_data = '0;
    logic        wr_ena = 1'b0;
    logic        full, overflow, idle, in_ena, rd_valid, timeout_err;
    logic [4:0]  level;
    logic [23:0] in_data, rd_data;
    logic        busy = 1'b0;
    logic [23:0] miso = '0;
    logic        miso_ena = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [23:0] obs_iss[$];
    logic [23:0] obs_rd[$];
    logic [23:0] exp_rd[$];
    logic [23:0] exp_iss[$];

    bit          m_auto = 1'b0;
    int          m_cnt = 0;
    logic [23:0] m_cmd = '0;
    logic        prev_ena = 1'b0;

    spi_cmd_sequencer #(.WIDTH(24), .DEPTH(16), .RD_FLAG_BIT(23), .TIMEOUT(8'd10)) dut (
        .sys_clk(sys_clk), .n_rst(n_rst),
        .i_wr_data(wr_data), .i_wr_ena(wr_ena),
        .o_full(full), .o_level(level), .o_overflow(overflow), .o_idle(idle),
        .o_spi_in_data(in_data), .o_spi_in_ena(in_ena), .i_spi_busy(busy),
        .i_spi_miso_reg(miso), .i_spi_miso_reg_ena(miso_ena),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Observer: every new frame request and every readback strobe
    initial begin
        forever begin
            @(negedge sys_clk);
            if (in_ena && !prev_ena) obs_iss.push_back(in_data);
            if (rd_valid) obs_rd.push_back(rd_data);
            prev_ena = in_ena;
        end
    end

    // Master model: busy rises the cycle after in_ena, lasts a random length, read frames return a random word
    initial begin
        forever begin
            @(negedge sys_clk);
            if (m_auto) begin
                miso_ena = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        busy = 1'b0;
                        if (m_cmd[23]) begin
                            miso = 24'($urandom);
                            miso_ena = 1'b1;
                            exp_rd.push_back(miso);
                        end
                    end
                end else if (in_ena && !busy) begin
                    busy  = 1'b1;
                    m_cmd = in_data;
                    m_cnt = $urandom_range(2, 6);
                end
            end
        end
    end

    task automatic wait_ena(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge sys_clk);
            if (in_ena) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge sys_clk);
            if (idle && !busy && m_cnt == 0) ok = 1'b1;
        end
        @(negedge sys_clk);
    endtask

    task automatic start_auto();
        busy = 1'b0; miso_ena = 1'b0; m_cnt = 0; exp_rd.delete(); m_auto = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_checks++; if (idle !== 1'b1)     begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
        n_checks++; if (in_ena !== 1'b0 || in_data !== 24'h0) begin n_fail++; $display("FAIL reset_spi got=%b/%h exp=0/000000", in_ena, in_data); end
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 24'h0) begin n_fail++; $display("FAIL reset_rd got=%b/%h exp=0/000000", rd_valid, rd_data); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_single_write();
        obs_iss.delete(); obs_rd.delete();
        wr_data = 24'h012345; wr_ena = 1'b1;
        @(negedge sys_clk); wr_ena = 1'b0;
        n_checks++; if (level !== 5'd1 || in_ena !== 1'b0) begin n_fail++; $display("FAIL single_after_write level=%0d ena=%b exp=1/0", level, in_ena); end
        @(negedge sys_clk);
        n_checks++; if (in_ena !== 1'b0 || in_data !== 24'h012345 || idle !== 1'b0) begin n_fail++; $display("FAIL single_pop ena=%b data=%h idle=%b exp=0/012345/0", in_ena, in_data, idle); end
        @(negedge sys_clk);
        n_checks++; if (in_ena !== 1'b1) begin n_fail++; $display("FAIL single_latency ena=%b exp=1", in_ena); end
        busy = 1'b1;
        @(negedge sys_clk);
        n_checks++; if (in_ena !== 1'b0) begin n_fail++; $display("FAIL single_ena_drop ena=%b exp=0", in_ena); end
        repeat (3) @(negedge sys_clk);
        n_checks++; if (in_data !== 24'h012345 || idle !== 1'b0) begin n_fail++; $display("FAIL single_hold data=%h idle=%b exp=012345/0", in_data, idle); end
        busy = 1'b0;
        @(negedge sys_clk);
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle got=%b exp=1", idle); end
        @(negedge sys_clk);
        n_checks++; if (obs_rd.size() != 0 || obs_iss.size() != 1) begin n_fail++; $display("FAIL single_counts rd=%0d iss=%0d exp=0/1", obs_rd.size(), obs_iss.size()); end
    endtask

    task automatic test_read();
        bit ok;
        obs_rd.delete();
        wr_data = 24'h80AB00; wr_ena = 1'b1;
        @(negedge sys_clk); wr_ena = 1'b0;
        wait_ena(10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read_issue in_ena never rose exp=1"); end
        busy = 1'b1;
        repeat (2) @(negedge sys_clk);
        miso = 24'h0000C3; miso_ena = 1'b1;
        @(negedge sys_clk); miso_ena = 1'b0;
        @(negedge sys_clk);
        miso = 24'hFFFFFF; miso_ena = 1'b1;
        @(negedge sys_clk); miso_ena = 1'b0; busy = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_checks++; if (obs_rd.size() != 1) begin n_fail++; $display("FAIL read_pulses got=%0d exp=1", obs_rd.size()); end
        else begin
            n_checks++; if (obs_rd[0] !== 24'h0000C3) begin n_fail++; $display("FAIL read_data got=%h exp=0000c3", obs_rd[0]); end
        end
        n_checks++; if (rd_data !== 24'h0000C3) begin n_fail++; $display("FAIL read_hold got=%h exp=0000c3", rd_data); end
    endtask

    task automatic test_full_overflow();
        bit ok;
        obs_iss.delete(); obs_rd.delete(); exp_iss.delete();
        busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 24'($urandom); wr_ena = 1'b1;
            exp_iss.push_back(wr_data);
            @(negedge sys_clk);
        end
        wr_ena = 1'b0;
        n_checks++; if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_state level=%0d full=%b ovf=%b exp=16/1/0", level, full, overflow); end
        wr_data = 24'hDEAD01; wr_ena = 1'b1;
        @(negedge sys_clk); wr_ena = 1'b0;
        n_checks++; if (overflow !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL overflow ovf=%b level=%0d exp=1/16", overflow, level); end
        start_auto();
        wait_idle(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_drain timed out exp=idle"); end
        n_checks++; if (obs_iss.size() != 16) begin n_fail++; $display("FAIL full_frames got=%0d exp=16", obs_iss.size()); end
        for (int i = 0; i < 16 && i < obs_iss.size(); i++) begin
            n_checks++; if (obs_iss[i] !== exp_iss[i]) begin n_fail++; $display("FAIL full_order[%0d] got=%h exp=%h", i, obs_iss[i], exp_iss[i]); end
        end
        n_checks++; if (obs_rd != exp_rd) begin n_fail++; $display("FAIL full_readback got=%0d words exp=%0d words", obs_rd.size(), exp_rd.size()); end
        m_auto = 1'b0;
    endtask

    task automatic test_simultaneous();
        bit ok;
        obs_iss.delete(); obs_rd.delete(); exp_iss.delete();
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 24'($urandom) & 24'h7FFFFF; wr_ena = 1'b1;
            exp_iss.push_back(wr_data);
            @(negedge sys_clk);
        end
        wr_ena = 1'b0;
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL simul_pre level=%0d exp=5", level); end
        busy = 1'b0; wr_data = 24'h5A5A5A; wr_ena = 1'b1;
        exp_iss.push_back(wr_data);
        @(negedge sys_clk); wr_ena = 1'b0;
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL simul_level got=%0d exp=5", level); end
        n_checks++; if (in_data !== exp_iss[0]) begin n_fail++; $display("FAIL simul_popped got=%h exp=%h", in_data, exp_iss[0]); end
        start_auto();
        wait_idle(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_drain timed out exp=idle"); end
        n_checks++; if (obs_iss != exp_iss) begin n_fail++; $display("FAIL simul_order got=%0d frames exp=%0d frames", obs_iss.size(), exp_iss.size()); end
        m_auto = 1'b0;
    endtask

    task automatic test_random_traffic();
        bit ok;
        obs_iss.delete(); obs_rd.delete(); exp_iss.delete();
        start_auto();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0 && !full) begin
                wr_data = 24'($urandom); wr_ena = 1'b1;
                exp_iss.push_back(wr_data);
            end else wr_ena = 1'b0;
            @(negedge sys_clk);
        end
        wr_ena = 1'b0;
        wait_idle(4000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL random_drain timed out exp=idle"); end
        n_checks++; if (obs_iss != exp_iss) begin n_fail++; $display("FAIL random_order got=%0d frames exp=%0d frames", obs_iss.size(), exp_iss.size()); end
        n_checks++; if (obs_rd != exp_rd) begin n_fail++; $display("FAIL random_readback got=%0d words exp=%0d words", obs_rd.size(), exp_rd.size()); end
        m_auto = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 24'h100000 + 24'(i); wr_ena = 1'b1;
            @(negedge sys_clk);
        end
        wr_ena = 1'b0; busy = 1'b0;
        wait_ena(10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_issue in_ena never rose exp=1"); end
        busy = 1'b1;
        @(negedge sys_clk);
        n_checks++; if (level !== 5'd3 || in_ena !== 1'b0) begin n_fail++; $display("FAIL midrst_pre level=%0d ena=%b exp=3/0", level, in_ena); end
        n_rst = 1'b0;
        #1;
        n_checks++; if (level !== 5'd0 || full !== 1'b0 || overflow !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL midrst_fifo level=%0d full=%b ovf=%b idle=%b exp=0/0/0/1", level, full, overflow, idle); end
        n_checks++; if (in_ena !== 1'b0 || in_data !== 24'h0 || rd_valid !== 1'b0 || rd_data !== 24'h0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL midrst_out ena=%b data=%h rdv=%b rd=%h tmo=%b exp=0/0/0/0/0", in_ena, in_data, rd_valid, rd_data, timeout_err); end
        @(negedge sys_clk); n_rst = 1'b1; busy = 1'b0;
        obs_iss.delete(); obs_rd.delete();
        repeat (20) @(negedge sys_clk);
        n_checks++; if (obs_iss.size() != 0 || obs_rd.size() != 0 || idle !== 1'b1) begin n_fail++; $display("FAIL midrst_quiet iss=%0d rd=%0d idle=%b exp=0/0/1", obs_iss.size(), obs_rd.size(), idle); end
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int cnt;
        obs_rd.delete();
        busy = 1'b0;
        wr_data = 24'h0A0001; wr_ena = 1'b1;
        @(negedge sys_clk); wr_data = 24'h0A0002;
        @(negedge sys_clk); wr_ena = 1'b0;
        wait_ena(10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_issue in_ena never rose exp=1"); end
        cnt = 0;
        while (in_ena && cnt < 50) begin cnt++; @(negedge sys_clk); end
        n_checks++; if (cnt != 10) begin n_fail++; $display("FAIL tmo_ena_cycles got=%0d exp=10", cnt); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
        wait_ena(10, ok);
        n_checks++; if (!ok || in_data !== 24'h0A0002) begin n_fail++; $display("FAIL tmo_next ok=%b data=%h exp=1/0a0002", ok, in_data); end
        wait_idle(100, ok);
        n_checks++; if (!ok || obs_rd.size() != 0) begin n_fail++; $display("FAIL tmo_end ok=%b rd=%0d exp=1/0", ok, obs_rd.size()); end
    endtask
`endif

    initial begin
        repeat (3) @(negedge sys_clk);
        test_reset();
        n_rst = 1'b1;
        @(negedge sys_clk);
        test_single_write();
        test_read();
        test_full_overflow();
        test_simultaneous();
        test_random_traffic();
        test_reset_midframe();
`ifdef SPI_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
